// File: rtl/m_unit_sequencer_pkg.sv
// Shared encodings for the RV32M sequencer: FSM states, func3 op selects and a sign helper.
package m_unit_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [5:0] CNT_LAST = 6'd31;

  // Two's-complement negate when neg is set; used for magnitudes and sign fixups.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/m_unit_sequencer_muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply step or one restoring-divide step per step_en.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step_en,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi_d,
  output logic [XLEN-1:0] lo_d
);

  logic [XLEN-1:0] hi_q, lo_q, opnd_q, opnd_d;
  logic [XLEN:0]   sum, shifted, diff;

  // Multiply: {hi,lo} is the 64-bit product/multiplier shifter; divide: hi is the
  // partial remainder and lo shifts the dividend out while the quotient shifts in.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (load) begin
      hi_d   = '0;
      lo_d   = a_in;
      opnd_d = b_in;
    end else if (step_en) begin
      if (is_div) begin
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (!diff[XLEN]) begin
          hi_d = diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        hi_d = sum[XLEN:1];
        lo_d = {sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/m_unit_sequencer.sv
// RV32M multi-cycle sequencer: FSM, fast-path detection, sign handling and writeback outputs.
module m_unit_sequencer
  import m_unit_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd,
  input  logic            pipeline_flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_file
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      func3_q, func3_d;
  logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            core_load, core_step;
  logic [XLEN-1:0] core_hi_d, core_lo_d;
  logic            op1_signed, op2_signed, sgn1, sgn2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, fast_res, final_res;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin : decode
    op1_signed = (func3 != F3_MULHU) && (func3 != F3_DIVU) && (func3 != F3_REMU);
    op2_signed = (func3 == F3_MUL) || (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
    sgn1       = op1_signed & op1[XLEN-1];
    sgn2       = op2_signed & op2[XLEN-1];
    mag1       = neg_if(sgn1, op1);
    mag2       = neg_if(sgn2, op2);
    div_zero   = func3[2] & (op2 == '0);
    div_ovf    = ((func3 == F3_DIV) || (func3 == F3_REM)) && (op1 == INT_MIN) && (op2 == '1);
    // func3[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) fast_res = func3[1] ? op1 : '1;
    else          fast_res = func3[1] ? '0 : INT_MIN;
  end

  always_comb begin : fixup
    prod     = {core_hi_d, core_lo_d};
    prod_fix = neg_res_q ? -prod : prod;
    if (func3_q[2])
      final_res = func3_q[1] ? neg_if(neg_rem_q, core_hi_d) : neg_if(neg_res_q, core_lo_d);
    else
      final_res = (func3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin : fsm
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    wb_rd_d   = wb_rd_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !pipeline_flush) begin
          func3_d   = func3;
          rd_d      = rd;
          neg_res_d = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
          cnt_d     = '0;
          if (div_zero || div_ovf) begin
            result_d = fast_res;
            wb_rd_d  = rd;
            state_d  = ST_DONE;
          end else begin
            core_load = 1'b1;
            state_d   = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (pipeline_flush) begin
          state_d = ST_IDLE;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q + 6'd1;
          // Last iteration: capture the fixed-up result so it is valid in the DONE cycle.
          if (cnt_q == CNT_LAST) begin
            result_d = final_res;
            wb_rd_d  = rd_q;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (core_load),
    .step_en (core_step),
    .is_div  (func3_q[2]),
    .a_in    (mag1),
    .b_in    (mag2),
    .hi_d    (core_hi_d),
    .lo_d    (core_lo_d)
  );

  assign stall       = rst_n & (((state_q == ST_IDLE) & start & ~pipeline_flush) | (state_q == ST_CALC));
  assign done        = rst_n & (state_q == ST_DONE) & ~pipeline_flush;
  assign result      = result_q;
  assign wb_rd       = wb_rd_q;
  assign wb_reg_file = done & (wb_rd_q != 5'd0);

endmodule

// File: tb/tb_m_unit_sequencer.sv
// Directed vector bench for m_unit_sequencer: table of ops plus flush/reset/DONE corner sequences.
module tb_m_unit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, pipeline_flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        stall, done, wb_reg_file;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  m_unit_sequencer #(.XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .func3          (func3),
    .op1            (op1),
    .op2            (op2),
    .rd             (rd),
    .pipeline_flush (pipeline_flush),
    .stall          (stall),
    .done           (done),
    .result         (result),
    .wb_rd          (wb_rd),
    .wb_reg_file    (wb_reg_file)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Issue one op at the next negedge (cycle 0) and follow it to its done pulse.
  task automatic run_op(input vec_t v);
    int          lat;
    int          stall_cnt;
    logic [31:0] res;
    logic        wbe;
    logic [4:0]  wrd;
    lat = -1; res = '0; wbe = 1'b0; wrd = '0;
    @(negedge clk);
    func3 = v.f3; op1 = v.a; op2 = v.b; rd = v.rd; start = 1'b1;
    #1;
    stall_cnt = int'(stall);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      start = 1'b0; op1 = 32'hDEADBEEF; op2 = 32'h12345678; rd = 5'd31;
      #1;
      stall_cnt += int'(stall);
      if (done) begin
        lat = c; res = result; wbe = wb_reg_file; wrd = wb_rd;
      end
    end
    $display("op %-14s a=%08h b=%08h rd=%0d -> result=%08h lat=%0d", v.nm, v.a, v.b, v.rd, res, lat);
    check({v.nm, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.nm, "_result"}, res, v.exp);
    check({v.nm, "_wb_reg_file"}, 32'(wbe), 32'(v.rd != 5'd0));
    check({v.nm, "_wb_rd"}, 32'(wrd), 32'(v.rd));
    check({v.nm, "_stall_cycles"}, 32'(stall_cnt), 32'(v.lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          done_at;
    int          done_cnt;
    logic [31:0] res;

    vecs[0]  = '{"MUL_7x-3",       3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33};
    vecs[1]  = '{"MULHU_max",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 33};
    vecs[2]  = '{"MULH_-1x-1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 33};
    vecs[3]  = '{"REM_-7_2",       3'd6, 32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFF, 33};
    vecs[4]  = '{"DIV_-7_2",       3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33};
    vecs[5]  = '{"DIVU_by0",       3'd5, 32'd123,      32'd0,        5'd6,  32'hFFFFFFFF, 1};
    vecs[6]  = '{"DIV_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 1};
    vecs[7]  = '{"REM_ovf_rd0",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1};
    vecs[8]  = '{"MULHSU_-1xmax",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33};
    vecs[9]  = '{"REMU_100_7",     3'd7, 32'd100,      32'd7,        5'd9,  32'd2,        33};
    vecs[10] = '{"DIVU_100_7",     3'd5, 32'd100,      32'd7,        5'd10, 32'd14,       33};
    vecs[11] = '{"REMU_by0_rd0",   3'd7, 32'd5,        32'd0,        5'd0,  32'd5,        1};
    vecs[12] = '{"MUL_3x4_rd0",    3'd0, 32'd3,        32'd4,        5'd0,  32'd12,       33};
    vecs[13] = '{"DIV_min_2",      3'd4, 32'h80000000, 32'd2,        5'd11, 32'hC0000000, 33};

    rst_n = 1'b0; start = 1'b0; pipeline_flush = 1'b0;
    func3 = '0; op1 = '0; op2 = '0; rd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_reg_file", 32'(wb_reg_file), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // start held into the DONE cycle of a fast-path op must not launch a second op
    @(negedge clk);
    func3 = 3'd5; op1 = 32'd9; op2 = 32'd0; rd = 5'd3; start = 1'b1;
    @(negedge clk); #1;
    $display("seq start_in_done: cycle1 done=%0d result=%08h", done, result);
    check("C_done_cycle1", 32'(done), 32'd1);
    @(negedge clk); start = 1'b0; #1;
    check("C_no_done_cycle2", 32'(done), 32'd0);
    check("C_no_stall_cycle2", 32'(stall), 32'd0);

    // Flush in cycle 10 of a DIVU, then a MUL started in cycle 12 completes in cycle 45
    @(negedge clk);
    func3 = 3'd5; op1 = 32'd1000; op2 = 32'd3; rd = 5'd11; start = 1'b1;
    #1;
    check("A_stall_cycle0", 32'(stall), 32'd1);
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) pipeline_flush = 1'b1;
      #1;
      done_cnt += int'(done);
    end
    check("A_stall_cycle10", 32'(stall), 32'd1);
    @(negedge clk); pipeline_flush = 1'b0; #1;
    check("A_stall_cycle11", 32'(stall), 32'd0);
    check("A_done_cycle11", 32'(done), 32'd0);
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd6; op2 = 32'd7; rd = 5'd12; start = 1'b1;
    #1;
    check("A_mul_stall_cycle12", 32'(stall), 32'd1);
    done_at = -1; res = '0;
    for (int c = 13; c <= 60 && done_at < 0; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (done) begin done_at = c; res = result; end
    end
    $display("seq flush_then_mul: flushed dones=%0d mul done_at=%0d result=%08h", done_cnt, done_at, res);
    check("A_flushed_done_count", 32'(done_cnt), 32'd0);
    check("A_mul_done_cycle", 32'(done_at), 32'd45);
    check("A_mul_result", res, 32'd42);

    // Flush in the DONE cycle suppresses done and the write enable
    @(negedge clk);
    func3 = 3'd7; op1 = 32'd100; op2 = 32'd7; rd = 5'd13; start = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    check("D_stall_cycle32", 32'(stall), 32'd1);
    @(negedge clk); pipeline_flush = 1'b1; #1;
    check("D_done_flushed", 32'(done), 32'd0);
    check("D_wb_flushed", 32'(wb_reg_file), 32'd0);
    @(negedge clk); pipeline_flush = 1'b0; #1;
    $display("seq flush_in_done: cycle34 done=%0d stall=%0d", done, stall);
    check("D_done_cycle34", 32'(done), 32'd0);

    // start together with flush in IDLE is not accepted
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd2; op2 = 32'd2; rd = 5'd4; start = 1'b1; pipeline_flush = 1'b1;
    #1;
    check("E_stall_start_flush", 32'(stall), 32'd0);
    @(negedge clk); start = 1'b0; pipeline_flush = 1'b0; #1;
    check("E_stall_next", 32'(stall), 32'd0);
    $display("seq start_with_flush: stall=%0d done=%0d", stall, done);

    // Reset in cycle 5 of a MUL clears everything and no done follows
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd3; op2 = 32'd5; rd = 5'd14; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 1'b0;
    end
    @(negedge clk); rst_n = 1'b0; #1;
    check("B_stall_in_reset", 32'(stall), 32'd0);
    @(negedge clk); #1;
    check("B_result_after_reset", result, 32'd0);
    check("B_wb_rd_after_reset", 32'(wb_rd), 32'd0);
    check("B_done_after_reset", 32'(done), 32'd0);
    check("B_wb_after_reset", 32'(wb_reg_file), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      done_cnt += int'(done);
    end
    $display("seq reset_mid_mul: dones after reset=%0d", done_cnt);
    check("B_no_done_after_reset", 32'(done_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
